match_sequencer: RTL and testbench
==================================

Name: match_sequencer

Overview:
- Frame-rate game-flow controller: title screen → round intro → fight → KO hold → match over.
- Drives game_mode, player freeze, round reset and KO frame count for box, p_health, box_color and rom_port_data.
- Counts round wins to a best-of match; consumes the USB keycode and both lose flags.
- Clocked by the VGA vertical-sync frame clock, so one cycle equals one frame.

Parameters:
- WINS_NEEDED, 2: round wins required to take the match.
- INTRO_FRAMES, 120: frozen "ready" frames before each fight.
- KO_FRAMES, 50: frames held after a KO before the round is scored.
- ROUND_SECS, 60: round length in seconds (ROUND_TIMER_EN only).
- FRAMES_PER_SEC, 60: frames per timer second.

Ports:
- frame_clk  in  1  frame clock (VGA_VS)
- Reset  in  1  asynchronous, active-high reset
- keycode  in  8  lowest USB keycode
- p1_lose  in  1  P1 health exhausted
- p2_lose  in  1  P2 health exhausted
- p1_health  in  10  P1 green bar width
- p2_health  in  10  P2 green bar width
- game_mode  out  3  000 title, 001 vs AI, 010 two-player
- freeze  out  1  players ignore input
- round_reset  out  1  one-frame pulse: restore health and positions
- count  out  9  KO frame counter
- round_num  out  3  current round, 1-based
- p1_wins  out  2  rounds won by P1
- p2_wins  out  2  rounds won by P2
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw
- timer_sec  out  7  seconds remaining

Behaviour:
- Reset (async, any state): state=TITLE, game_mode=000, freeze=1, round_reset=0, count=0, round_num=1, wins=0, winner=00, timer_sec=0.
- Key press: keycode==K this frame and prev_keycode!=K; prev_keycode register resets to 00. Holding a key fires once.
- Keys: 1E selects AI, 1F selects two-player, 15 restarts.
- TITLE:
  - Press 1E → game_mode=001; press 1F → game_mode=010.
  - Either press → INTRO, with round_reset=1 for the first INTRO frame, round_num=1, wins cleared.
- INTRO:
  - freeze=1; an internal counter runs 0..INTRO_FRAMES-1.
  - At the last frame → FIGHT, freeze=0; timer_sec loads ROUND_SECS.
- FIGHT:
  - Any lose flag → KO; count=0; freeze=1.
  - Both flags in the same frame → draw.
- KO:
  - count increments each frame, saturates at KO_FRAMES.
  - On the frame count reaches KO_FRAMES, score the round:
    - p2_lose only → p1_wins+1.
    - p1_lose only → p2_wins+1.
    - Both → no award, round_num unchanged.
  - If a win counter reaches WINS_NEEDED → MATCH_OVER, winner set.
  - Otherwise round_num+1 (except after a draw) → INTRO with round_reset pulse; count cleared on INTRO entry.
- MATCH_OVER:
  - freeze=1; count holds KO_FRAMES; game_mode holds.
  - Press 15 → TITLE, all counters cleared.
- Restart: press 15 in INTRO, FIGHT or KO → TITLE next frame, same as reset. Press 15 in TITLE is ignored.
- Lose flags outside FIGHT are ignored.
- Priority:
  - Restart beats KO entry in the same frame.
  - 1E beats 1F is impossible: one keycode per frame.
- Counters are saturating; none wrap. round_num saturates at 7.

Optional Feature:
- ROUND_TIMER_EN defined:
  - In FIGHT, a frame prescaler counts 0..FRAMES_PER_SEC-1; timer_sec decrements on wrap.
  - When timer_sec hits 0 with no lose flag → KO path. The lower health loses; equal health is a draw.
  - The timeout verdict is latched as synthetic lose flags for scoring.
- ROUND_TIMER_EN not defined:
  - timer_sec held at 0 and the prescaler is absent.
  - Rounds end only on lose flags.

Decomposition:
- Package match_pkg:
  - State enum: TITLE, INTRO, FIGHT, KO, MATCH_OVER.
  - Mode constants: MODE_TITLE=3'b000, MODE_AI=3'b001, MODE_2P=3'b010.
  - Key constants: KEY_1=8'h1E, KEY_2=8'h1F, KEY_R=8'h15.
  - Winner encodings.
- Sub-module round_timer: prescaler plus seconds down-counter with load/enable/expired. Instantiated only under ROUND_TIMER_EN.

Test Plan:
- Reset, hold keycode=1F for 3 frames → game_mode=010 once; round_reset high exactly 1 frame; freeze=0 after 120 frames.
- In FIGHT, p2_lose=1 → freeze=1 next frame; count reaches 50 at frame 50; p1_wins=1, round_num=2, INTRO re-entered.
- p1_lose and p2_lose asserted in the same frame → winner unchanged, no win awarded, round_num unchanged, next INTRO.
- P1 wins two rounds → MATCH_OVER, winner=01, count held 50; keycode=15 → TITLE, game_mode=000, wins=0.
- Press 15 mid-FIGHT, and assert Reset asynchronously mid-KO → TITLE, all outputs at reset values, with no frame-clock edge needed for Reset.
- ROUND_TIMER_EN, ROUND_SECS=2, p1_health=80, p2_health=120 → timer_sec 2→1→0 over 120 frames; KO path; p2_wins=1.

Source files
------------

// File: rtl/match_pkg.sv
// Shared types and constants for the match_sequencer game-flow controller.
package match_pkg;

   typedef enum logic [2:0] {
      TITLE,
      INTRO,
      FIGHT,
      KO,
      MATCH_OVER
   } state_t;

   localparam logic [2:0] MODE_TITLE = 3'b000;
   localparam logic [2:0] MODE_AI    = 3'b001;
   localparam logic [2:0] MODE_2P    = 3'b010;

   localparam logic [7:0] KEY_1 = 8'h1E;
   localparam logic [7:0] KEY_2 = 8'h1F;
   localparam logic [7:0] KEY_R = 8'h15;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   // A press is the first frame a key appears; holding it does not repeat.
   function automatic logic key_pressed(input logic [7:0] key,
                                        input logic [7:0] prev_key,
                                        input logic [7:0] target);
      return (key == target) && (prev_key != target);
   endfunction

   function automatic logic [1:0] sat_inc2(input logic [1:0] v);
      return (v == 2'b11) ? v : v + 2'd1;
   endfunction

endpackage

// File: rtl/round_timer.sv
// Round clock: frame prescaler feeding a seconds down-counter.
// Compiled only when ROUND_TIMER_EN is defined.
`ifdef ROUND_TIMER_EN
module round_timer #(
   parameter int unsigned ROUND_SECS     = 60,
   parameter int unsigned FRAMES_PER_SEC = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       clear,
   input  logic       en,
   output logic [6:0] sec,
   output logic       expired
);
   localparam int unsigned PW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(FRAMES_PER_SEC - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [6:0]    sec_q, sec_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         sec_q   <= '0;
      end else begin
         presc_q <= presc_d;
         sec_q   <= sec_d;
      end
   end

   always_comb begin
      presc_d = presc_q;
      sec_d   = sec_q;
      if (clear) begin
         presc_d = '0;
         sec_d   = '0;
      end else if (load) begin
         presc_d = '0;
         sec_d   = 7'(ROUND_SECS);
      end else if (en) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (sec_q != 7'd0)
               sec_d = sec_q - 7'd1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   assign sec     = sec_q;
   assign expired = (sec_q == 7'd0);

endmodule
`endif

// File: rtl/match_sequencer.sv
// Frame-rate game flow: title -> intro -> fight -> KO hold -> match over.
// Define ROUND_TIMER_EN to add the per-round countdown with health-based timeout verdict.
module match_sequencer
   import match_pkg::*;
#(
   parameter int unsigned WINS_NEEDED    = 2,
   parameter int unsigned INTRO_FRAMES   = 120,
   parameter int unsigned KO_FRAMES      = 50,
   parameter int unsigned ROUND_SECS     = 60,
   parameter int unsigned FRAMES_PER_SEC = 60
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic       p1_lose,
   input  logic       p2_lose,
   input  logic [9:0] p1_health,
   input  logic [9:0] p2_health,
   output logic [2:0] game_mode,
   output logic       freeze,
   output logic       round_reset,
   output logic [8:0] count,
   output logic [2:0] round_num,
   output logic [1:0] p1_wins,
   output logic [1:0] p2_wins,
   output logic [1:0] winner,
   output logic [6:0] timer_sec
);
   localparam int unsigned IW = (INTRO_FRAMES > 1) ? $clog2(INTRO_FRAMES) : 1;
   localparam logic [IW-1:0] INTRO_LAST = IW'(INTRO_FRAMES - 1);
   localparam logic [8:0] KO_END   = 9'(KO_FRAMES);
   localparam logic [8:0] KO_SCORE = KO_END - 9'd1;
   localparam logic [1:0] WINS_GOAL = 2'(WINS_NEEDED);

   state_t        state_q, state_d;
   logic [7:0]    prev_key_q;
   logic [2:0]    game_mode_q, game_mode_d;
   logic [8:0]    count_q, count_d;
   logic [2:0]    round_num_q, round_num_d;
   logic [1:0]    p1_wins_q, p1_wins_d;
   logic [1:0]    p2_wins_q, p2_wins_d;
   logic [1:0]    winner_q, winner_d;
   logic [IW-1:0] intro_cnt_q, intro_cnt_d;
   logic          ko_p1_q, ko_p1_d;
   logic          ko_p2_q, ko_p2_d;

   logic          press_ai, press_2p, restart;
   logic [6:0]    timer_sec_w;
   logic          timer_expired;
   logic          timeout_p1_lose, timeout_p2_lose;

   assign press_ai = key_pressed(keycode, prev_key_q, KEY_1);
   assign press_2p = key_pressed(keycode, prev_key_q, KEY_2);
   assign restart  = key_pressed(keycode, prev_key_q, KEY_R) && (state_q != TITLE);

`ifdef ROUND_TIMER_EN
   round_timer #(
      .ROUND_SECS     (ROUND_SECS),
      .FRAMES_PER_SEC (FRAMES_PER_SEC)
   ) u_round_timer (
      .clk     (frame_clk),
      .rst     (Reset),
      .load    ((state_q == INTRO) && (intro_cnt_q == INTRO_LAST) && !restart),
      .clear   (restart),
      .en      ((state_q == FIGHT) && !restart),
      .sec     (timer_sec_w),
      .expired (timer_expired)
   );
   // Equal health flags both players, which scores as a draw.
   assign timeout_p1_lose = (p1_health <= p2_health);
   assign timeout_p2_lose = (p2_health <= p1_health);
`else
   localparam int unsigned UNUSED_TIMER_CFG = ROUND_SECS + FRAMES_PER_SEC;
   logic unused_health;
   assign unused_health   = ^{p1_health, p2_health};
   assign timer_sec_w     = '0;
   assign timer_expired   = 1'b0;
   assign timeout_p1_lose = 1'b0;
   assign timeout_p2_lose = 1'b0;
`endif

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= TITLE;
         prev_key_q  <= '0;
         game_mode_q <= MODE_TITLE;
         count_q     <= '0;
         round_num_q <= 3'd1;
         p1_wins_q   <= '0;
         p2_wins_q   <= '0;
         winner_q    <= WIN_NONE;
         intro_cnt_q <= '0;
         ko_p1_q     <= 1'b0;
         ko_p2_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_key_q  <= keycode;
         game_mode_q <= game_mode_d;
         count_q     <= count_d;
         round_num_q <= round_num_d;
         p1_wins_q   <= p1_wins_d;
         p2_wins_q   <= p2_wins_d;
         winner_q    <= winner_d;
         intro_cnt_q <= intro_cnt_d;
         ko_p1_q     <= ko_p1_d;
         ko_p2_q     <= ko_p2_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      game_mode_d = game_mode_q;
      count_d     = count_q;
      round_num_d = round_num_q;
      p1_wins_d   = p1_wins_q;
      p2_wins_d   = p2_wins_q;
      winner_d    = winner_q;
      intro_cnt_d = intro_cnt_q;
      ko_p1_d     = ko_p1_q;
      ko_p2_d     = ko_p2_q;

      case (state_q)
         TITLE: begin
            if (press_ai || press_2p) begin
               game_mode_d = press_ai ? MODE_AI : MODE_2P;
               state_d     = INTRO;
               intro_cnt_d = '0;
               round_num_d = 3'd1;
               p1_wins_d   = '0;
               p2_wins_d   = '0;
               winner_d    = WIN_NONE;
               count_d     = '0;
            end
         end
         INTRO: begin
            if (intro_cnt_q == INTRO_LAST)
               state_d = FIGHT;
            else
               intro_cnt_d = intro_cnt_q + IW'(1);
         end
         FIGHT: begin
            if (p1_lose || p2_lose) begin
               state_d = KO;
               count_d = '0;
               ko_p1_d = p1_lose;
               ko_p2_d = p2_lose;
            end else if (timer_expired) begin
               state_d = KO;
               count_d = '0;
               ko_p1_d = timeout_p1_lose;
               ko_p2_d = timeout_p2_lose;
            end
         end
         KO: begin
            // Score on the edge count reaches KO_FRAMES; leave KO one frame later.
            if (count_q != KO_END) begin
               count_d = count_q + 9'd1;
               if (count_q == KO_SCORE) begin
                  if (ko_p2_q && !ko_p1_q) p1_wins_d = sat_inc2(p1_wins_q);
                  if (ko_p1_q && !ko_p2_q) p2_wins_d = sat_inc2(p2_wins_q);
               end
            end else if (p1_wins_q >= WINS_GOAL) begin
               state_d  = MATCH_OVER;
               winner_d = WIN_P1;
            end else if (p2_wins_q >= WINS_GOAL) begin
               state_d  = MATCH_OVER;
               winner_d = WIN_P2;
            end else begin
               state_d     = INTRO;
               intro_cnt_d = '0;
               count_d     = '0;
               if (!(ko_p1_q && ko_p2_q) && (round_num_q != 3'd7))
                  round_num_d = round_num_q + 3'd1;
            end
         end
         MATCH_OVER: begin
         end
         default: state_d = TITLE;
      endcase

      if (restart) begin
         state_d     = TITLE;
         game_mode_d = MODE_TITLE;
         count_d     = '0;
         round_num_d = 3'd1;
         p1_wins_d   = '0;
         p2_wins_d   = '0;
         winner_d    = WIN_NONE;
         intro_cnt_d = '0;
         ko_p1_d     = 1'b0;
         ko_p2_d     = 1'b0;
      end
   end

   always_comb begin
      freeze      = (state_q != FIGHT);
      round_reset = (state_q == INTRO) && (intro_cnt_q == '0);
   end

   assign game_mode = game_mode_q;
   assign count     = count_q;
   assign round_num = round_num_q;
   assign p1_wins   = p1_wins_q;
   assign p2_wins   = p2_wins_q;
   assign winner    = winner_q;
   assign timer_sec = timer_sec_w;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: menu, intro, KO scoring, draws, match over, restart and async reset.
module tb_match_sequencer;

   logic       frame_clk;
   logic       Reset;
   logic [7:0] keycode;
   logic       p1_lose, p2_lose;
   logic [9:0] p1_health, p2_health;
   logic [2:0] game_mode;
   logic       freeze, round_reset;
   logic [8:0] count;
   logic [2:0] round_num;
   logic [1:0] p1_wins, p2_wins, winner;
   logic [6:0] timer_sec;

   int tests  = 0;
   int failed = 0;
   int rr_seen;

   match_sequencer #(
      .WINS_NEEDED    (2),
      .INTRO_FRAMES   (120),
      .KO_FRAMES      (50),
      .ROUND_SECS     (2),
      .FRAMES_PER_SEC (60)
   ) dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .keycode     (keycode),
      .p1_lose     (p1_lose),
      .p2_lose     (p2_lose),
      .p1_health   (p1_health),
      .p2_health   (p2_health),
      .game_mode   (game_mode),
      .freeze      (freeze),
      .round_reset (round_reset),
      .count       (count),
      .round_num   (round_num),
      .p1_wins     (p1_wins),
      .p2_wins     (p2_wins),
      .winner      (winner),
      .timer_sec   (timer_sec)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge frame_clk);
         #2;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_mode"},   32'(game_mode), 32'h0);
      check({tag, "_freeze"}, 32'(freeze),    32'h1);
      check({tag, "_rr"},     32'(round_reset), 32'h0);
      check({tag, "_count"},  32'(count),     32'h0);
      check({tag, "_round"},  32'(round_num), 32'h1);
      check({tag, "_wins"},   32'({p1_wins, p2_wins}), 32'h0);
      check({tag, "_winner"}, 32'(winner),    32'h0);
      check({tag, "_timer"},  32'(timer_sec), 32'h0);
   endtask

   initial begin
      Reset = 1'b1;
      keycode = 8'h00;
      p1_lose = 1'b0;
      p2_lose = 1'b0;
      p1_health = 10'd80;
      p2_health = 10'd120;
      #1;
      check_reset_state("por");
      step(2);
      Reset = 1'b0;

      // Hold 1F for three frames: one press, one round_reset frame
      keycode = 8'h1F;
      step(1);
      check("sel2p_mode", 32'(game_mode), 32'h2);
      check("sel2p_rr_first", 32'(round_reset), 32'h1);
      check("sel2p_freeze", 32'(freeze), 32'h1);
      rr_seen = 0;
      step(2);
      if (round_reset) rr_seen++;
      keycode = 8'h00;
      for (int i = 0; i < 116; i++) begin
         step(1);
         if (round_reset) rr_seen++;
      end
      check("intro_rr_once", 32'(rr_seen), 32'h0);
      step(1);
      check("intro_frozen_119", 32'(freeze), 32'h1);
      step(1);
      check("fight_unfrozen", 32'(freeze), 32'h0);
      check("fight_mode_held", 32'(game_mode), 32'h2);
`ifdef ROUND_TIMER_EN
      check("fight_timer_load", 32'(timer_sec), 32'h2);
`else
      check("fight_timer_zero", 32'(timer_sec), 32'h0);
`endif

      // Round 1: P2 KO'd
      p2_lose = 1'b1;
      step(1);
      p2_lose = 1'b0;
      check("ko_freeze", 32'(freeze), 32'h1);
      check("ko_count0", 32'(count), 32'h0);
      step(49);
      check("ko_count49", 32'(count), 32'd49);
      check("ko_nowin_yet", 32'(p1_wins), 32'h0);
      step(1);
      check("ko_count50", 32'(count), 32'd50);
      check("r1_p1_wins", 32'(p1_wins), 32'h1);
      check("r1_p2_wins", 32'(p2_wins), 32'h0);
      step(1);
      check("r2_round", 32'(round_num), 32'h2);
      check("r2_rr", 32'(round_reset), 32'h1);
      check("r2_count_clr", 32'(count), 32'h0);

      // Lose flag during INTRO must be ignored
      p1_lose = 1'b1;
      step(5);
      check("intro_lose_ignored", 32'(freeze), 32'h1);
      check("intro_lose_count", 32'(count), 32'h0);
      p1_lose = 1'b0;
      step(115);
      check("r2_fight", 32'(freeze), 32'h0);

      // Round 2: double KO is a draw
      p1_lose = 1'b1;
      p2_lose = 1'b1;
      step(1);
      p1_lose = 1'b0;
      p2_lose = 1'b0;
      check("draw_ko", 32'(freeze), 32'h1);
      step(50);
      check("draw_count50", 32'(count), 32'd50);
      check("draw_wins", 32'({p1_wins, p2_wins}), 32'b0100);
      step(1);
      check("draw_round_same", 32'(round_num), 32'h2);
      check("draw_winner", 32'(winner), 32'h0);
      check("draw_rr", 32'(round_reset), 32'h1);
      step(120);
      check("r3_fight", 32'(freeze), 32'h0);

      // Round 3: P1 takes the match
      p2_lose = 1'b1;
      step(1);
      p2_lose = 1'b0;
      step(50);
      check("r3_p1_wins", 32'(p1_wins), 32'h2);
      step(1);
      check("mo_winner", 32'(winner), 32'h1);
      check("mo_freeze", 32'(freeze), 32'h1);
      check("mo_count", 32'(count), 32'd50);
      step(3);
      check("mo_count_held", 32'(count), 32'd50);
      check("mo_mode_held", 32'(game_mode), 32'h2);
      keycode = 8'h15;
      step(1);
      keycode = 8'h00;
      check_reset_state("mo_restart");

      // Restart mid-FIGHT beats a simultaneous KO
      keycode = 8'h1E;
      step(1);
      keycode = 8'h00;
      check("selai_mode", 32'(game_mode), 32'h1);
      step(120);
      check("ai_fight", 32'(freeze), 32'h0);
      keycode = 8'h15;
      p1_lose = 1'b1;
      step(1);
      keycode = 8'h00;
      p1_lose = 1'b0;
      check_reset_state("fight_restart");
      step(1);
      keycode = 8'h15;
      step(1);
      keycode = 8'h00;
      check("title_r_ignored", 32'(game_mode), 32'h0);
      step(1);

      // Async reset mid-KO, no clock edge
      keycode = 8'h1F;
      step(1);
      keycode = 8'h00;
      step(120);
      p1_lose = 1'b1;
      step(1);
      p1_lose = 1'b0;
      step(10);
      check("ko_mid_count", 32'(count), 32'd10);
      #3;
      Reset = 1'b1;
      #1;
      check_reset_state("async_rst");
      step(1);
      Reset = 1'b0;

`ifdef ROUND_TIMER_EN
      // Timeout: lower-health P1 loses the round
      keycode = 8'h1E;
      step(1);
      keycode = 8'h00;
      step(120);
      check("tmr_start", 32'(timer_sec), 32'h2);
      step(60);
      check("tmr_1", 32'(timer_sec), 32'h1);
      step(60);
      check("tmr_0", 32'(timer_sec), 32'h0);
      check("tmr_still_fight", 32'(freeze), 32'h0);
      step(1);
      check("tmr_ko", 32'(freeze), 32'h1);
      step(50);
      check("tmr_p2_wins", 32'(p2_wins), 32'h1);
      check("tmr_p1_wins", 32'(p1_wins), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
